fazyrv_rf_seq: RTL and testbench

//  Parametrised register-file front end for the chunked FazyRV datapath. Fetches NRS source operands

---
 rtl/fazyrv_rf_seq_if.sv | 31 +++
 rtl/fazyrv_rf_seq.sv | 192 +++++++++++++++++++
 tb/tb_fazyrv_rf_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fazyrv_rf_seq_if.sv
// Register-file RAM bus between fazyrv_rf_seq (master) and the RF RAM (slave):
// NRP synchronous read ports sharing one enable, plus one write port.
interface fazyrv_rf_seq_if #(
    parameter int NRP      = 1,
    parameter int ADRWIDTH = 5
);
    logic                    re;
    logic [NRP*ADRWIDTH-1:0] raddr;
    logic [NRP*32-1:0]       rdata;
    logic                    we;
    logic [ADRWIDTH-1:0]     waddr;
    logic [31:0]             wdata;

    modport master (
        output re,
        output raddr,
        input  rdata,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        input  re,
        input  raddr,
        output rdata,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface

// File: rtl/fazyrv_rf_seq.sv
// Register-file front end for the chunked FazyRV datapath: fetches up to three source
// operands over NRP RAM read ports, serves them chunk-wise, and collects rd for one write.
module fazyrv_rf_seq #(
    parameter int CHUNKSIZE = 2,
    parameter int NRS       = 2,
    parameter int NRP       = 1,
    parameter int ADRWIDTH  = 5,
    parameter int BYPASS    = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_in,
    input  logic                     rd_req_i,
    input  logic                     flush_i,
    input  logic [NRS*5-1:0]         rs_i,
    output logic                     busy_o,
    output logic                     rs_vld_o,
    input  logic                     shft_i,
    output logic [NRS*CHUNKSIZE-1:0] rs_o,
    input  logic [4:0]               rd_i,
    input  logic [CHUNKSIZE-1:0]     res_i,
    input  logic                     we_i,
    input  logic                     wstb_i,
    fazyrv_rf_seq_if.master          ram
);

    localparam int R = (NRS + NRP - 1) / NRP;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RET   = 2'd2;
    localparam logic [1:0] S_LOAD  = 2'd3;
    localparam logic [1:0] S_VLD   = (BYPASS != 0) ? S_RET : S_LOAD;

    function automatic logic [31:0] rotr(input logic [31:0] x);
        return (x >> CHUNKSIZE) | (x << (32 - CHUNKSIZE));
    endfunction

    function automatic logic [31:0] shift_in(input logic [31:0] x, input logic [CHUNKSIZE-1:0] c);
        return (x >> CHUNKSIZE) | (32'(c) << (32 - CHUNKSIZE));
    endfunction

    logic [1:0]              state_q, state_d;
    logic [1:0]              rnd_q, rnd_d;
    logic                    cap_q, cap_d;
    logic [1:0]              cap_rnd_q, cap_rnd_d;
    logic [NRP-1:0]          fwd_q, fwd_d;
    logic [31:0]             fwd_data_q;
    logic [31:0]             op_q [NRS];
    logic [31:0]             op_d [NRS];
    logic [31:0]             rdb_q, rdb_d;

    logic                    issue;
    logic [1:0]              issue_rnd;
    logic [NRP*ADRWIDTH-1:0] raddr;
    logic                    wr_en;
    logic [ADRWIDTH-1:0]     wr_addr;
    logic [31:0]             pd [NRP];

    // Sequencer: round 0 goes out in the request cycle, later rounds one per cycle
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        issue     = 1'b0;
        issue_rnd = rnd_q;
        case (state_q)
            S_IDLE: begin
                issue_rnd = 2'd0;
                if (rd_req_i) begin
                    issue   = 1'b1;
                    rnd_d   = 2'd1;
                    state_d = (R > 1) ? S_ISSUE : S_RET;
                end
            end
            S_ISSUE: begin
                issue = 1'b1;
                if (rnd_q == 2'(R - 1)) begin
                    state_d = S_RET;
                end else begin
                    rnd_d = rnd_q + 2'd1;
                end
            end
            S_RET:   state_d = (BYPASS != 0) ? S_IDLE : S_LOAD;
            S_LOAD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            rnd_d   = 2'd0;
            issue   = 1'b0;
        end
        if (state_d == S_IDLE) begin
            rnd_d = 2'd0;
        end
    end

    always_comb begin
        raddr = '0;
        for (int n = 0; n < NRS; n++) begin
            if (n / NRP == int'(issue_rnd)) begin
                raddr[(n % NRP)*ADRWIDTH +: ADRWIDTH] = ADRWIDTH'(rs_i[5*n +: 5]);
            end
        end
    end

    assign wr_en   = rst_in & wstb_i & we_i & (rd_i != 5'd0);
    assign wr_addr = ADRWIDTH'(rd_i);

    // A port whose read collides with this cycle's write takes the write data next cycle
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            fwd_d[p] = issue && wr_en
                       && (wr_addr == raddr[p*ADRWIDTH +: ADRWIDTH])
                       && (raddr[p*ADRWIDTH +: ADRWIDTH] != '0);
        end
    end

    assign cap_d     = issue;
    assign cap_rnd_d = issue_rnd;

    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            pd[p] = fwd_q[p] ? fwd_data_q : ram.rdata[32*p +: 32];
        end
    end

    // Operand buffers: capture the returning round, everything else rotates on shft_i
    always_comb begin
        for (int n = 0; n < NRS; n++) begin
            op_d[n] = op_q[n];
            if (cap_q && !flush_i && (n / NRP == int'(cap_rnd_q))) begin
                op_d[n] = ((BYPASS != 0) && shft_i) ? rotr(pd[n % NRP]) : pd[n % NRP];
            end else if (shft_i) begin
                op_d[n] = rotr(op_q[n]);
            end
        end
    end

    always_comb begin
        rs_o = '0;
        for (int n = 0; n < NRS; n++) begin
            rs_o[n*CHUNKSIZE +: CHUNKSIZE] = op_q[n][CHUNKSIZE-1:0];
            if ((BYPASS != 0) && (state_q == S_RET) && cap_q && (n / NRP == int'(cap_rnd_q))) begin
                rs_o[n*CHUNKSIZE +: CHUNKSIZE] = pd[n % NRP][CHUNKSIZE-1:0];
            end
        end
    end

    always_comb begin
        rdb_d = rdb_q;
        if (!wstb_i && shft_i) begin
            rdb_d = we_i ? shift_in(rdb_q, res_i) : rotr(rdb_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            rnd_q     <= 2'd0;
            cap_q     <= 1'b0;
            cap_rnd_q <= 2'd0;
            fwd_q     <= '0;
            rdb_q     <= '0;
            for (int n = 0; n < NRS; n++) begin
                op_q[n] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            cap_q     <= cap_d;
            cap_rnd_q <= cap_rnd_d;
            fwd_q     <= fwd_d;
            rdb_q     <= rdb_d;
            for (int n = 0; n < NRS; n++) begin
                op_q[n] <= op_d[n];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        fwd_data_q <= rdb_q;
    end

    assign ram.re    = rst_in & issue;
    assign ram.raddr = raddr;
    assign ram.we    = wr_en;
    assign ram.waddr = wr_addr;
    assign ram.wdata = rdb_q;

    assign busy_o   = (state_q != S_IDLE);
    assign rs_vld_o = (state_q == S_VLD) & ~flush_i;

endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Directed bench for fazyrv_rf_seq: a two-operand/one-port instance without bypass and a
// three-operand/two-port instance with bypass, each backed by a small synchronous RAM.
module tb_fazyrv_rf_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_req = 0, a_flush = 0, a_shft = 0, a_we = 0, a_wstb = 0;
    logic [9:0]  a_rs = '0;
    logic [4:0]  a_rd = '0;
    logic [1:0]  a_res = '0;
    logic        a_busy, a_vld;
    logic [3:0]  a_rso;

    logic        b_req = 0, b_flush = 0, b_shft = 0, b_we = 0, b_wstb = 0;
    logic [14:0] b_rs = '0;
    logic [4:0]  b_rd = '0;
    logic [1:0]  b_res = '0;
    logic        b_busy, b_vld;
    logic [5:0]  b_rso;

    fazyrv_rf_seq_if #(.NRP(1), .ADRWIDTH(5)) ifa ();
    fazyrv_rf_seq_if #(.NRP(2), .ADRWIDTH(5)) ifb ();

    fazyrv_rf_seq #(.CHUNKSIZE(2), .NRS(2), .NRP(1), .ADRWIDTH(5), .BYPASS(0)) dut_a (
        .clk_i(clk), .rst_in(rst_n), .rd_req_i(a_req), .flush_i(a_flush), .rs_i(a_rs),
        .busy_o(a_busy), .rs_vld_o(a_vld), .shft_i(a_shft), .rs_o(a_rso), .rd_i(a_rd),
        .res_i(a_res), .we_i(a_we), .wstb_i(a_wstb), .ram(ifa)
    );

    fazyrv_rf_seq #(.CHUNKSIZE(2), .NRS(3), .NRP(2), .ADRWIDTH(5), .BYPASS(1)) dut_b (
        .clk_i(clk), .rst_in(rst_n), .rd_req_i(b_req), .flush_i(b_flush), .rs_i(b_rs),
        .busy_o(b_busy), .rs_vld_o(b_vld), .shft_i(b_shft), .rs_o(b_rso), .rd_i(b_rd),
        .res_i(b_res), .we_i(b_we), .wstb_i(b_wstb), .ram(ifb)
    );

    // Read-before-write RAMs; preload port lets the bench seed contents
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    logic        pre_en = 0;
    logic        pre_sel = 0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (ifa.re) ifa.rdata <= mem_a[ifa.raddr];
        if (ifa.we) mem_a[ifa.waddr] <= ifa.wdata;
        if (pre_en && !pre_sel) mem_a[pre_addr] <= pre_data;
    end

    always @(posedge clk) begin
        if (ifb.re) begin
            ifb.rdata[31:0]  <= mem_b[ifb.raddr[4:0]];
            ifb.rdata[63:32] <= mem_b[ifb.raddr[9:5]];
        end
        if (ifb.we) mem_b[ifb.waddr] <= ifb.wdata;
        if (pre_en && pre_sel) mem_b[pre_addr] <= pre_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic sel, input logic [4:0] addr, input logic [31:0] data);
        pre_sel = sel; pre_addr = addr; pre_data = data; pre_en = 1;
        step();
        pre_en = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; a_req = 1; a_wstb = 1; a_we = 1; a_rd = 5'd5;
        #12;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", a_busy); end
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b want 0", a_vld); end
        checks++; if (a_rso !== 4'b0) begin errors++; $display("FAIL rst_rso got %b want 0000", a_rso); end
        checks++; if (ifa.re !== 1'b0) begin errors++; $display("FAIL rst_re got %b want 0", ifa.re); end
        checks++; if (ifa.we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", ifa.we); end
        checks++; if (b_rso !== 6'b0) begin errors++; $display("FAIL rst_b_rso got %b want 000000", b_rso); end
        a_req = 0; a_wstb = 0; a_we = 0; a_rd = '0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_fetch();
        step();
        a_rs = {5'd2, 5'd1}; a_req = 1;
        #1;
        checks++; if (ifa.re !== 1'b1 || ifa.raddr !== 5'd1) begin errors++; $display("FAIL fetch_r0 got re=%b addr=%0d want re=1 addr=1", ifa.re, ifa.raddr); end
        step();
        a_req = 0;
        #1;
        checks++; if (ifa.re !== 1'b1 || ifa.raddr !== 5'd2) begin errors++; $display("FAIL fetch_r1 got re=%b addr=%0d want re=1 addr=2", ifa.re, ifa.raddr); end
        checks++; if (a_busy !== 1'b1 || a_vld !== 1'b0) begin errors++; $display("FAIL fetch_t1 got busy=%b vld=%b want busy=1 vld=0", a_busy, a_vld); end
        step();
        checks++; if (a_vld !== 1'b0 || ifa.re !== 1'b0) begin errors++; $display("FAIL fetch_t2 got vld=%b re=%b want 0 0", a_vld, ifa.re); end
        step();
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL fetch_vld_t3 got %b want 1", a_vld); end
        checks++; if (a_rso !== 4'b0111) begin errors++; $display("FAIL fetch_rso got %b want 0111", a_rso); end
        a_shft = 1;
        repeat (15) step();
        checks++; if (a_rso !== 4'b1000) begin errors++; $display("FAIL fetch_shift15 got %b want 1000", a_rso); end
        step();
        a_shft = 0;
        checks++; if (a_rso !== 4'b0111) begin errors++; $display("FAIL fetch_shift16 got %b want 0111", a_rso); end
        checks++; if (a_busy !== 1'b0 || a_vld !== 1'b0) begin errors++; $display("FAIL fetch_idle got busy=%b vld=%b want 0 0", a_busy, a_vld); end
    endtask

    task automatic test_rs3_bypass();
        step();
        b_rs = {5'd7, 5'd6, 5'd5}; b_req = 1;
        #1;
        checks++; if (ifb.re !== 1'b1 || ifb.raddr !== {5'd6, 5'd5}) begin errors++; $display("FAIL rs3_r0 got re=%b addr=%h want re=1 addr=%h", ifb.re, ifb.raddr, {5'd6, 5'd5}); end
        step();
        b_req = 0;
        #1;
        checks++; if (ifb.re !== 1'b1 || ifb.raddr !== {5'd0, 5'd7}) begin errors++; $display("FAIL rs3_r1 got re=%b addr=%h want re=1 addr=%h", ifb.re, ifb.raddr, {5'd0, 5'd7}); end
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL rs3_vld_t1 got %b want 0", b_vld); end
        step();
        b_shft = 1;
        #1;
        checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL rs3_vld_t2 got %b want 1", b_vld); end
        checks++; if (b_rso !== 6'b111001) begin errors++; $display("FAIL rs3_bypass_rso got %b want 111001", b_rso); end
        step();
        b_shft = 0;
        #1;
        checks++; if (b_vld !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rs3_t3 got vld=%b busy=%b want 0 0", b_vld, b_busy); end
        checks++; if (b_rso !== 6'b100101) begin errors++; $display("FAIL rs3_rot_capture got %b want 100101", b_rso); end
    endtask

    task automatic test_write();
        step();
        a_rd = 5'd3; a_we = 1; a_res = 2'b10; a_shft = 1;
        repeat (16) step();
        a_shft = 0; a_wstb = 1;
        #1;
        checks++; if (ifa.we !== 1'b1 || ifa.waddr !== 5'd3) begin errors++; $display("FAIL wr_strobe got we=%b addr=%0d want we=1 addr=3", ifa.we, ifa.waddr); end
        checks++; if (ifa.wdata !== 32'hAAAA_AAAA) begin errors++; $display("FAIL wr_data got %h want aaaaaaaa", ifa.wdata); end
        step();
        checks++; if (mem_a[3] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL wr_mem got %h want aaaaaaaa", mem_a[3]); end
        a_rd = 5'd0;
        #1;
        checks++; if (ifa.we !== 1'b0) begin errors++; $display("FAIL wr_x0 got we=%b want 0", ifa.we); end
        a_rd = 5'd3; a_we = 0;
        #1;
        checks++; if (ifa.we !== 1'b0) begin errors++; $display("FAIL wr_nowe got we=%b want 0", ifa.we); end
        a_wstb = 0;
    endtask

    task automatic test_forward();
        logic [31:0] fv;
        logic [31:0] got;
        fv = 32'h1234_5678;
        got = '0;
        step();
        a_rd = 5'd4; a_we = 1; a_shft = 1;
        for (int i = 0; i < 16; i++) begin
            a_res = fv[2*i +: 2];
            step();
        end
        a_shft = 0; a_wstb = 1; a_req = 1; a_rs = {5'd0, 5'd4};
        #1;
        checks++; if (ifa.we !== 1'b1 || ifa.re !== 1'b1 || ifa.raddr !== 5'd4) begin errors++; $display("FAIL fwd_collide got we=%b re=%b raddr=%0d want 1 1 4", ifa.we, ifa.re, ifa.raddr); end
        step();
        a_wstb = 0; a_we = 0; a_req = 0;
        repeat (2) step();
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL fwd_vld got %b want 1", a_vld); end
        a_shft = 1;
        for (int i = 0; i < 16; i++) begin
            got[2*i +: 2] = a_rso[1:0];
            step();
        end
        a_shft = 0;
        checks++; if (got !== 32'h1234_5678) begin errors++; $display("FAIL fwd_operand got %h want 12345678", got); end
        checks++; if (mem_a[4] !== 32'h1234_5678) begin errors++; $display("FAIL fwd_mem got %h want 12345678", mem_a[4]); end
    endtask

    task automatic test_flush();
        logic seen;
        step();
        a_rs = {5'd2, 5'd1}; a_req = 1;
        step();
        a_req = 0; a_flush = 1;
        #1;
        checks++; if (ifa.re !== 1'b0) begin errors++; $display("FAIL flush_no_issue got re=%b want 0", ifa.re); end
        step();
        a_flush = 0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", a_busy); end
        seen = 0;
        repeat (4) begin
            if (a_vld !== 1'b0) seen = 1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_vld got pulse=%b want 0", seen); end
        a_req = 1; a_flush = 1;
        #1;
        checks++; if (ifa.re !== 1'b0) begin errors++; $display("FAIL flush_req_re got %b want 0", ifa.re); end
        step();
        a_req = 0; a_flush = 0;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL flush_req_busy got %b want 0", a_busy); end
        a_req = 1;
        step();
        a_req = 0;
        repeat (2) step();
        checks++; if (a_vld !== 1'b1 || a_rso !== 4'b0111) begin errors++; $display("FAIL flush_refetch got vld=%b rso=%b want 1 0111", a_vld, a_rso); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        step();
        a_rs = {5'd2, 5'd1}; a_req = 1;
        step();
        a_req = 0;
        #1;
        rst_n = 0;
        #1;
        checks++; if (a_busy !== 1'b0 || ifa.re !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got busy=%b re=%b want 0 0", a_busy, ifa.re); end
        checks++; if (a_rso !== 4'b0) begin errors++; $display("FAIL rstmid_rso got %b want 0000", a_rso); end
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (6) begin
            step();
            if (a_vld !== 1'b0) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_vld got pulse=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        preload(1'b0, 5'd0, 32'h0);
        preload(1'b0, 5'd1, 32'h0000_0003);
        preload(1'b0, 5'd2, 32'h8000_0001);
        preload(1'b0, 5'd4, 32'hDEAD_BEEF);
        preload(1'b1, 5'd0, 32'h0);
        preload(1'b1, 5'd5, 32'h0000_0005);
        preload(1'b1, 5'd6, 32'h0000_0006);
        preload(1'b1, 5'd7, 32'h0000_000B);
        test_fetch();
        test_rs3_bypass();
        test_write();
        test_forward();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
